// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline defines: word/instruction widths, register address width,
// hazard controller state type and stall counter width.
package pipeline_hazard_ctrl_pkg;

    localparam int WORD_LEN        = 32;
    localparam int INSTRUCTION_LEN = 32;
    localparam int REG_ADDR_LEN    = 3;
    localparam int STALL_CNT_LEN   = 16;

    typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

    typedef enum logic {
        RUN  = 1'b0,
        MEMW = 1'b1
    } hazard_state_e;

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic srcMatch(input logic vld, input reg_addr_t src, input reg_addr_t dst);
        return vld && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detection between the ID sources and the EX/MEM destinations.
// FORWARDING_EN: only load-use stalls; otherwise any in-flight producer stalls.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic      id_src1_i,
    input  logic      id_src1_vld_i,
    input  reg_addr_t id_src1_addr_i,
    input  logic      id_src2_vld_i,
    input  reg_addr_t id_src2_addr_i,
    input  reg_addr_t ex_dst_i,
    input  logic      ex_wr_en_i,
    input  logic      ex_mem_read_i,
    input  reg_addr_t mem_dst_i,
    input  logic      mem_wr_en_i,
    output logic      hazard_o
);

    logic exMatch;
    logic memMatch;
    logic unused_in;

    assign exMatch  = srcMatch(id_src1_vld_i, id_src1_addr_i, ex_dst_i)
                    | srcMatch(id_src2_vld_i, id_src2_addr_i, ex_dst_i);
    assign memMatch = srcMatch(id_src1_vld_i, id_src1_addr_i, mem_dst_i)
                    | srcMatch(id_src2_vld_i, id_src2_addr_i, mem_dst_i);

`ifdef FORWARDING_EN
    // ALU results are forwarded, so only a load in EX cannot be bypassed in time.
    assign hazard_o  = ex_mem_read_i & ex_wr_en_i & exMatch;
    assign unused_in = id_src1_i ^ memMatch ^ mem_wr_en_i;
`else
    assign hazard_o  = (ex_wr_en_i & exMatch) | (mem_wr_en_i & memMatch);
    assign unused_in = id_src1_i ^ ex_mem_read_i;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, branch flush, data-hazard stall and stall counter.
// Build option: FORWARDING_EN selects load-use-only hazard detection.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_LEN-1:0]  id_src1,
    input  logic [REG_ADDR_LEN-1:0]  id_src2,
    input  logic                     id_src1_vld,
    input  logic                     id_src2_vld,
    input  logic [REG_ADDR_LEN-1:0]  ex_dst,
    input  logic                     ex_wr_en,
    input  logic                     ex_mem_read,
    input  logic [REG_ADDR_LEN-1:0]  mem_dst,
    input  logic                     mem_wr_en,
    input  logic                     br_taken,
    input  logic                     dmem_req,
    input  logic                     dmem_ack,
    output logic                     pc_en,
    output logic                     if_id_en,
    output logic                     id_ex_en,
    output logic                     ex_mem_en,
    output logic                     if_id_flush,
    output logic                     id_ex_bubble,
    output logic [STALL_CNT_LEN-1:0] stall_cnt
);

    hazard_state_e            state_q, state_d;
    logic [STALL_CNT_LEN-1:0] stallCnt_q, stallCnt_d;
    logic                     hazard;
    logic                     memWait;

    hazard_detect u_hazard_detect (
        .id_src1_i      (1'b0),
        .id_src1_vld_i  (id_src1_vld),
        .id_src1_addr_i (id_src1),
        .id_src2_vld_i  (id_src2_vld),
        .id_src2_addr_i (id_src2),
        .ex_dst_i       (ex_dst),
        .ex_wr_en_i     (ex_wr_en),
        .ex_mem_read_i  (ex_mem_read),
        .mem_dst_i      (mem_dst),
        .mem_wr_en_i    (mem_wr_en),
        .hazard_o       (hazard)
    );

    // A zero-wait access (req and ack together) never freezes; the ack cycle itself runs normally.
    always_comb begin
        memWait = 1'b0;
        if (state_q == RUN) begin
            memWait = dmem_req & ~dmem_ack;
        end else begin
            memWait = ~dmem_ack;
        end
        state_d = memWait ? MEMW : RUN;
    end

    // Priority: reset, memory freeze, branch redirect, data hazard, normal flow.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst || memWait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (!pc_en && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; expectations follow the FORWARDING_EN build option.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] EXP_RUN    = 6'b1111_00;
    localparam logic [5:0] EXP_STALL  = 6'b0011_01;
    localparam logic [5:0] EXP_BRANCH = 6'b1111_11;
    localparam logic [5:0] EXP_FROZEN = 6'b0000_00;
`ifdef FORWARDING_EN
    localparam logic [5:0] EXP_MEM_DEP = EXP_RUN;
    localparam logic [5:0] EXP_ALU_DEP = EXP_RUN;
`else
    localparam logic [5:0] EXP_MEM_DEP = EXP_STALL;
    localparam logic [5:0] EXP_ALU_DEP = EXP_STALL;
`endif

    typedef struct {
        string       tag;
        logic [5:0]  vec;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_src1, id_src2, ex_dst, mem_dst;
    logic        id_src1_vld, id_src2_vld, ex_wr_en, ex_mem_read, mem_wr_en;
    logic        br_taken, dmem_req, dmem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble;
    logic [15:0] stall_cnt;

    exp_t        scoreboard[$];
    logic [15:0] expCnt = '0;
    int          checkCount = 0;
    int          passCount = 0;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_vld  (id_src1_vld),
        .id_src2_vld  (id_src2_vld),
        .ex_dst       (ex_dst),
        .ex_wr_en     (ex_wr_en),
        .ex_mem_read  (ex_mem_read),
        .mem_dst      (mem_dst),
        .mem_wr_en    (mem_wr_en),
        .br_taken     (br_taken),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        id_src1 = '0; id_src2 = '0; id_src1_vld = 1'b0; id_src2_vld = 1'b0;
        ex_dst = '0; ex_wr_en = 1'b0; ex_mem_read = 1'b0;
        mem_dst = '0; mem_wr_en = 1'b0;
        br_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic sampleOutputs();
        exp_t e;
        e = scoreboard.pop_front();
        checkOutput({e.tag, "_ctl"},
                    {10'b0, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble},
                    {10'b0, e.vec});
        checkOutput({e.tag, "_cnt"}, stall_cnt, e.cnt);
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic applyStimulus(input string tag, input logic [5:0] expVec);
        exp_t e;
        if (rst) expCnt = '0;
        e.tag = tag;
        e.vec = expVec;
        e.cnt = expCnt;
        scoreboard.push_back(e);
        if (!rst && !expVec[5] && expCnt != 16'hFFFF) expCnt++;
        #2;
        sampleOutputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        @(negedge clk);
        applyStimulus("reset0", EXP_FROZEN);
        dmem_req = 1'b1;
        applyStimulus("reset1", EXP_FROZEN);
        rst = 1'b0;
        clearInputs();
        applyStimulus("idle", EXP_RUN);

        ex_mem_read = 1'b1; ex_wr_en = 1'b1; ex_dst = 3'd3; id_src1 = 3'd3; id_src1_vld = 1'b1;
        applyStimulus("loaduse", EXP_STALL);
        ex_mem_read = 1'b0; ex_wr_en = 1'b0; ex_dst = 3'd0; mem_dst = 3'd3; mem_wr_en = 1'b1;
        applyStimulus("loaduse_mem", EXP_MEM_DEP);
        clearInputs();
        applyStimulus("loaduse_done", EXP_RUN);

        ex_mem_read = 1'b1; ex_wr_en = 1'b1; ex_dst = 3'd0; id_src1 = 3'd0; id_src1_vld = 1'b1;
        applyStimulus("load_r0", EXP_RUN);
        ex_dst = 3'd5; id_src2 = 3'd5; id_src2_vld = 1'b0;
        applyStimulus("load_novld", EXP_RUN);
        id_src2_vld = 1'b1;
        applyStimulus("load_src2", EXP_STALL);
        clearInputs();

        ex_wr_en = 1'b1; ex_dst = 3'd2; id_src2 = 3'd2; id_src2_vld = 1'b1;
        applyStimulus("alu_ex", EXP_ALU_DEP);
        ex_wr_en = 1'b0; ex_dst = 3'd0; mem_wr_en = 1'b1; mem_dst = 3'd2;
        applyStimulus("alu_mem", EXP_ALU_DEP);
        clearInputs();
        applyStimulus("alu_done", EXP_RUN);

        dmem_req = 1'b1;
        applyStimulus("memw1", EXP_FROZEN);
        dmem_req = 1'b0;
        applyStimulus("memw2", EXP_FROZEN);
        br_taken = 1'b1;
        applyStimulus("memw3", EXP_FROZEN);
        applyStimulus("memw4", EXP_FROZEN);
        dmem_ack = 1'b1;
        applyStimulus("memw_ack_br", EXP_BRANCH);
        clearInputs();
        applyStimulus("memw_after", EXP_RUN);

        dmem_req = 1'b1; dmem_ack = 1'b1;
        applyStimulus("zero_wait", EXP_RUN);
        clearInputs();
        applyStimulus("zero_wait_next", EXP_RUN);

        br_taken = 1'b1; ex_mem_read = 1'b1; ex_wr_en = 1'b1; ex_dst = 3'd4; id_src1 = 3'd4; id_src1_vld = 1'b1;
        applyStimulus("branch_wins", EXP_BRANCH);
        clearInputs();

        dmem_req = 1'b1;
        applyStimulus("ack_haz1", EXP_FROZEN);
        dmem_req = 1'b0; dmem_ack = 1'b1; ex_wr_en = 1'b1; ex_mem_read = 1'b1; ex_dst = 3'd6;
        id_src1 = 3'd6; id_src1_vld = 1'b1;
        applyStimulus("ack_haz2", EXP_STALL);
        clearInputs();

        dmem_req = 1'b1;
        applyStimulus("rstmw1", EXP_FROZEN);
        dmem_req = 1'b0;
        applyStimulus("rstmw2", EXP_FROZEN);
        rst = 1'b1;
        applyStimulus("rstmw_rst", EXP_FROZEN);
        rst = 1'b0;
        applyStimulus("rstmw_after", EXP_RUN);

        dmem_req = 1'b1;
        applyStimulus("sat_enter", EXP_FROZEN);
        dmem_req = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            if (expCnt != 16'hFFFF) expCnt++;
        end
        applyStimulus("sat_hold", EXP_FROZEN);
        dmem_ack = 1'b1;
        applyStimulus("sat_release", EXP_RUN);
        clearInputs();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
